// File: rtl/mux_scan16.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan16
//  Purpose  : Scan sequencer for a 16:1 gate multiplexer. Walks SEL through
//             channels 0..15, holds each for SETTLE_CYCLES cycles, samples
//             SIG on the last cycle of each window, and hands the assembled
//             16-bit word downstream over a single-slot valid/ready port.
//             Supports single-shot and continuous scanning with a sticky
//             overrun flag for words dropped while the slot is full.
//  Ports    : CLK        - clock, all state on rising edge
//             RESET      - asynchronous active-high reset
//             START      - begin a scan when idle (pulse or level)
//             CONTINUOUS - restart immediately at scan completion when high
//             SEL[3:0]   - registered multiplexer select
//             SIG        - multiplexer output
//             DATA[15:0] - last completed word, DATA[k] sampled at SEL==k
//             VALID      - DATA holds an unconsumed word
//             READY      - consumer accepts DATA when VALID && READY
//             BUSY       - scan in progress
//             OVERRUN    - sticky: a completed word was dropped
//             CLR_OVR    - synchronous clear of OVERRUN
//  Revision : 1.0 - initial release
// ============================================================================
module mux_scan16 #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        CONTINUOUS,
    output logic [3:0]  SEL,
    input  logic        SIG,
    output logic [15:0] DATA,
    output logic        VALID,
    input  logic        READY,
    output logic        BUSY,
    output logic        OVERRUN,
    input  logic        CLR_OVR
);

    localparam logic [CNT_W-1:0] c_reload = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [3:0]       sel_q,    sel_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      data_q,   data_d;
    logic             valid_q,  valid_d;
    logic             ovr_q,    ovr_d;

    logic             w_slot_free;
    logic             w_drop;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            sel_q    <= 4'd0;
            cnt_q    <= c_reload;
            shadow_q <= 16'd0;
            data_q   <= 16'd0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        w_drop   = 1'b0;

        // The slot is free when empty or being emptied by this very handshake,
        // which lets a new word load on the same edge the old one is taken.
        w_slot_free = !valid_q || READY;

        if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                sel_d = 4'd0;
                if (START) begin
                    state_d = ST_SCAN;
                    cnt_d   = c_reload;
                end
            end

            ST_SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shadow_d[sel_q] = SIG;
                    cnt_d           = c_reload;
                    if (sel_q != 4'hF) begin
                        sel_d = sel_q + 4'd1;
                    end else begin
                        // Completion: shadow_d already carries bit 15 = SIG.
                        sel_d = 4'd0;
                        if (w_slot_free) begin
                            data_d  = shadow_d;
                            valid_d = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                        if (!CONTINUOUS) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = 4'd0;
            end
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (w_drop) begin
            ovr_d = 1'b1;
        end else if (CLR_OVR) begin
            ovr_d = 1'b0;
        end
    end

    assign SEL     = sel_q;
    assign DATA    = data_q;
    assign VALID   = valid_q;
    assign BUSY    = (state_q == ST_SCAN);
    assign OVERRUN = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan16
//  Purpose  : Self-checking bench for mux_scan16. A behavioural model tracks
//             the scan schedule in cycles, drives SIG from a per-scan pattern
//             (with the wrong value outside the sampling cycle), and pushes
//             each delivered word into a scoreboard queue that a monitor
//             drains on every VALID && READY handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan16;

    localparam int S        = 3;
    localparam int SCAN_LEN = 16 * S;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, cont, sig, ready, clr_ovr;
    logic [3:0]  sel;
    logic [15:0] data;
    logic        valid, busy, ovr;

    logic        start1, sig1;
    logic [3:0]  sel1;
    logic [15:0] data1;
    logic        valid1, busy1, ovr1;
    logic [15:0] pat1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_scan16 #(.SETTLE_CYCLES(S), .CNT_W(8)) u_dut (
        .CLK(clk), .RESET(rst), .START(start), .CONTINUOUS(cont),
        .SEL(sel), .SIG(sig), .DATA(data), .VALID(valid), .READY(ready),
        .BUSY(busy), .OVERRUN(ovr), .CLR_OVR(clr_ovr)
    );

    mux_scan16 #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .CLK(clk), .RESET(rst), .START(start1), .CONTINUOUS(1'b0),
        .SEL(sel1), .SIG(sig1), .DATA(data1), .VALID(valid1), .READY(1'b1),
        .BUSY(busy1), .OVERRUN(ovr1), .CLR_OVR(1'b0)
    );

    assign pat1 = 16'hA5C3;
    assign sig1 = pat1[sel1];

    // ------------------------------------------------------------------------
    // Reference model state (values describe the current clock cycle)
    // ------------------------------------------------------------------------
    bit          m_busy, m_full, m_ovr, m_last;
    int          m_cyc, m_scans;
    logic [3:0]  m_bit;
    logic [15:0] cur_pat;
    logic [15:0] pat_q[$];
    logic [15:0] exp_q[$];
    bit          p_start, p_cont, p_ready, p_clr;
    bit          comp, drop, starting;
    int          n_hs;

    // Correct channel value only in the last cycle of each settle window.
    assign sig = m_busy ? (m_last ? cur_pat[m_bit] : ~cur_pat[m_bit]) : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] next_pat();
        if (pat_q.size() > 0) return pat_q.pop_front();
        return 16'($urandom);
    endfunction

    // Model advance + scoreboard monitor
    initial begin
        m_busy = 0; m_full = 0; m_ovr = 0; m_cyc = 0; m_scans = 0;
        m_bit = 4'd0; m_last = 0; cur_pat = 16'd0; n_hs = 0;
        p_start = 0; p_cont = 0; p_ready = 0; p_clr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_full = 0; m_ovr = 0; m_cyc = 0;
                exp_q.delete();
                chk("data_rst", 32'(data), 32'd0);
            end else begin
                comp = 0; drop = 0; starting = 0;
                if (m_full && p_ready) m_full = 0;
                if (m_busy) begin
                    if (m_cyc == SCAN_LEN - 1) begin
                        comp = 1;
                        m_cyc = 0;
                        if (p_cont) starting = 1;
                        else m_busy = 0;
                    end else begin
                        m_cyc++;
                    end
                end else if (p_start) begin
                    m_busy = 1; m_cyc = 0; starting = 1;
                end
                if (comp) begin
                    if (!m_full) begin
                        exp_q.push_back(cur_pat);
                        m_full = 1;
                    end else begin
                        drop = 1;
                    end
                end
                if (starting) begin
                    cur_pat = next_pat();
                    m_scans++;
                end
                if (drop) m_ovr = 1;
                else if (p_clr) m_ovr = 0;
            end
            m_bit  = 4'(m_cyc / S);
            m_last = ((m_cyc % S) == S - 1);

            chk("busy", 32'(busy), 32'(m_busy));
            chk("sel", 32'(sel), m_busy ? 32'(m_cyc / S) : 32'd0);
            chk("valid", 32'(valid), 32'(m_full));
            chk("overrun", 32'(ovr), 32'(m_ovr));
            if (valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL data: got %0h, expected no word presented at %0t", data, $time);
                end else begin
                    chk("data", 32'(data), 32'(exp_q[0]));
                    if (ready) begin
                        void'(exp_q.pop_front());
                        n_hs++;
                    end
                end
            end
            p_start = start; p_cont = cont; p_ready = ready; p_clr = clr_ovr;
        end
    end

    task automatic wait_model(input int scans, input int cyc, input string name);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 3000) begin
            @(negedge clk); #1;
            n++;
            hit = m_busy && (m_scans == scans) && (m_cyc == cyc);
        end
        if (!hit) begin
            n_tests++; n_fail++;
            $display("FAIL %s: timeout waiting for scan %0d cycle %0d", name, scans, cyc);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || m_busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy || m_busy) begin
            n_tests++; n_fail++;
            $display("FAIL %s: timeout waiting for idle, busy=%0d", name, busy);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    // Stimulus
    initial begin
        int lat;
        int base;
        int hs0;
        rst = 1; start = 0; cont = 0; ready = 0; clr_ovr = 0; start1 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overrun", 32'(ovr), 32'd0);

        // Single scan, one settle cycle per channel
        start1 = 1; lat = 0;
        do begin
            @(posedge clk); #1;
            start1 = 0; lat++;
        end while (!valid1 && lat < 100);
        chk("s1_latency", 32'(lat), 32'd17);
        chk("s1_data", 32'(data1), 32'hA5C3);
        chk("s1_busy_after", 32'(busy1), 32'd0);
        chk("s1_sel_after", 32'(sel1), 32'd0);
        @(posedge clk); #1;
        chk("s1_valid_consumed", 32'(valid1), 32'd0);
        chk("s1_overrun", 32'(ovr1), 32'd0);

        // Settle timing with three cycles per channel
        ready = 1;
        pat_q.push_back(16'h3C96);
        @(posedge clk); #1 start = 1; lat = 0;
        do begin
            @(posedge clk); #1;
            start = 0; lat++;
        end while (!valid && lat < 200);
        chk("s3_latency", 32'(lat), 32'd49);
        chk("s3_data", 32'(data), 32'h3C96);
        wait_idle("s3_idle");

        // Continuous with backpressure
        repeat (3) @(posedge clk);
        #1 ready = 0; cont = 1;
        pat_q.push_back(16'h1234);
        pat_q.push_back(16'hFFFF);
        base = m_scans;
        pulse_start();
        wait_model(base + 3, 0, "bp_third_scan");
        chk("bp_overrun_set", 32'(ovr), 32'd1);
        chk("bp_data_held", 32'(data), 32'h1234);
        chk("bp_valid_held", 32'(valid), 32'd1);
        @(posedge clk); #1 clr_ovr = 1;
        @(posedge clk); #1 clr_ovr = 0;
        chk("bp_overrun_cleared", 32'(ovr), 32'd0);
        cont = 0;
        wait_idle("bp_idle");
        @(posedge clk); #1 ready = 1;
        repeat (3) @(posedge clk);
        #1 clr_ovr = 1;
        @(posedge clk); #1 clr_ovr = 0;

        // Same-cycle consume and load
        ready = 0; cont = 1;
        pat_q.push_back(16'h0F0F);
        pat_q.push_back(16'hBEEF);
        base = m_scans;
        pulse_start();
        wait_model(base + 2, SCAN_LEN - 2, "sc_wait");
        @(posedge clk); #1 ready = 1; cont = 0;
        @(posedge clk); #1 ready = 0;
        chk("sc_valid_stays", 32'(valid), 32'd1);
        chk("sc_data_new", 32'(data), 32'hBEEF);
        chk("sc_overrun", 32'(ovr), 32'd0);
        wait_idle("sc_idle");
        @(posedge clk); #1 ready = 1;
        repeat (2) @(posedge clk);

        // Reset mid-scan
        #1 cont = 0;
        base = m_scans;
        pulse_start();
        wait_model(base + 1, 7 * S, "rst_wait");
        #1 rst = 1;
        #1;
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_data", 32'(data), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_overrun", 32'(ovr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        pat_q.push_back(16'hC3A5);
        @(posedge clk); #1 start = 1; lat = 0;
        do begin
            @(posedge clk); #1;
            start = 0; lat++;
        end while (!valid && lat < 200);
        chk("rst_rescan_data", 32'(data), 32'hC3A5);
        wait_idle("rst_idle");

        // START ignored while busy
        hs0 = n_hs;
        base = m_scans;
        pulse_start();
        wait_model(base + 1, 5 * S, "ign_wait");
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        chk("ign_sel_continues", 32'(sel), 32'd5);
        wait_idle("ign_idle");
        repeat (4) @(posedge clk);
        #1;
        chk("ign_one_word", 32'(n_hs - hs0), 32'd1);
        chk("ign_scan_count", 32'(m_scans - base), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            start   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) cont = $urandom_range(0, 1) != 0;
            ready   = ($urandom_range(0, 1) == 0);
            clr_ovr = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #1 start = 0; cont = 0; clr_ovr = 0; ready = 1;
        wait_idle("final_idle");
        repeat (4) @(posedge clk);
        #1;
        chk("final_valid_drained", 32'(valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
